// File: rtl/fft_axil_regs.sv
// fft_axil_regs: AXI4-Lite slave holding the four 32-bit control registers
// of the FFT IP. Write and read channels run independently, with one
// transaction outstanding per channel. Register contents go to the FFT
// datapath on reg_out, together with a one-cycle write strobe per register
// and a start pulse.
// Optional feature macro: FFT_AXIL_WSTRB_EN. When it is defined, WSTRB
// byte lanes gate the register update. When it is undefined, every write
// replaces all 32 bits.
module fft_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
   output logic [3:0]                      reg_wr_stb,
   output logic                            fft_start
);

   localparam int DW = C_S_AXI_DATA_WIDTH;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [DW-1:0] reg_file [4];
   logic [DW-1:0] rdata_q;
   logic [3:0]    wr_stb_q;
   logic          start_q;
   logic          aw_ready;
   logic          w_ready;
   logic          b_valid;
   logic          ar_ready;
   logic          r_valid;
   logic          wr_en;
   logic          rd_en;
   logic [1:0]    w_idx;
   logic [1:0]    r_idx;
   logic          unused_inputs;

   assign w_idx = S_AXI_AWADDR[3:2];
   assign r_idx = S_AXI_ARADDR[3:2];
   assign wr_en = aw_ready;
   assign rd_en = ar_ready;

`ifdef FFT_AXIL_WSTRB_EN
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                            S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                            S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB};
`endif

   // Write and read FSM state registers; reset drops any open transaction.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   // Write channel: accept AW and W only together, then hold B until it is taken.
   always_comb begin
      w_next   = w_state;
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               aw_ready = 1'b1;
               w_ready  = 1'b1;
               w_next   = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (S_AXI_BREADY) begin
               w_next = W_IDLE;
            end
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Read channel: accept AR in idle, then hold R until the master takes it.
   always_comb begin
      r_next   = r_state;
      ar_ready = 1'b0;
      r_valid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (S_AXI_ARVALID) begin
               ar_ready = 1'b1;
               r_next   = R_DATA;
            end
         end
         R_DATA: begin
            r_valid = 1'b1;
            if (S_AXI_RREADY) begin
               r_next = R_IDLE;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Register file update plus the one-cycle write strobe and start pulse.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < 4; i++) begin
            reg_file[i] <= '0;
         end
         wr_stb_q <= '0;
         start_q  <= 1'b0;
      end else begin
         wr_stb_q <= '0;
         start_q  <= 1'b0;
         if (wr_en) begin
`ifdef FFT_AXIL_WSTRB_EN
            for (int k = 0; k < DW/8; k++) begin
               if (S_AXI_WSTRB[k]) begin
                  reg_file[w_idx][8*k +: 8] <= S_AXI_WDATA[8*k +: 8];
               end
            end
            start_q <= (w_idx == 2'd0) && S_AXI_WDATA[0] && S_AXI_WSTRB[0];
`else
            reg_file[w_idx] <= S_AXI_WDATA;
            start_q <= (w_idx == 2'd0) && S_AXI_WDATA[0];
`endif
            wr_stb_q <= 4'b0001 << w_idx;
         end
      end
   end

   // Capture read data at the AR handshake; a same-edge write is not yet visible.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= reg_file[r_idx];
      end
   end

   assign S_AXI_AWREADY = aw_ready;
   assign S_AXI_WREADY  = w_ready;
   assign S_AXI_BVALID  = b_valid;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = ar_ready;
   assign S_AXI_RVALID  = r_valid;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign reg_out       = {reg_file[3], reg_file[2], reg_file[1], reg_file[0]};
   assign reg_wr_stb    = wr_stb_q;
   assign fft_start     = start_q;

endmodule

// File: tb/tb_fft_axil_regs.sv
// tb_fft_axil_regs: directed self-checking bench for fft_axil_regs.
// Expected read data is pushed to a scoreboard queue when a read is issued
// and popped when RVALID is seen. The bench follows FFT_AXIL_WSTRB_EN the
// same way the design does.
module tb_fft_axil_regs;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   awaddr = '0;
   logic [2:0]   awprot = '0;
   logic         awvalid = 1'b0;
   logic         awready;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready = 1'b1;
   logic [3:0]   araddr = '0;
   logic [2:0]   arprot = '0;
   logic         arvalid = 1'b0;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready = 1'b1;
   logic [127:0] reg_out;
   logic [3:0]   reg_wr_stb;
   logic         fft_start;

   int           checks = 0;
   int           errors = 0;
   logic [31:0]  model [4];
   logic [31:0]  expq [$];
   logic [31:0]  old_val;
   logic [31:0]  exp_strb_val;

   fft_axil_regs dut (
      .ACLK          (clk),
      .ARESETN       (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_out       (reg_out),
      .reg_wr_stb    (reg_wr_stb),
      .fft_start     (fft_start)
   );

   // 100 MHz free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_d,
                                         input logic [31:0] new_d,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_d;
`ifdef FFT_AXIL_WSTRB_EN
      for (int k = 0; k < 4; k++) begin
         if (strb[k]) r[8*k +: 8] = new_d[8*k +: 8];
      end
`else
      r = new_d;
      if (strb == 4'hF) r = new_d;
`endif
      return r;
   endfunction

   function automatic logic start_expected(input logic [3:0] addr,
                                           input logic [31:0] data,
                                           input logic [3:0] strb);
`ifdef FFT_AXIL_WSTRB_EN
      return (addr[3:2] == 2'd0) && data[0] && strb[0];
`else
      return (addr[3:2] == 2'd0) && data[0] && (strb === strb);
`endif
   endfunction

   // One full write: handshake, then check response, strobe, and start pulse timing.
   task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data,
                                input logic [3:0] strb);
      int cyc;
      logic exp_start;
      logic [3:0] exp_stb;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      #1;
      cyc = 0;
      while (!(awready && wready) && cyc < 20) begin
         @(negedge clk); #1; cyc++;
      end
      checkOutput("aw_w_handshake", {127'd0, (cyc < 20)}, 128'd1);
      exp_start = start_expected(addr, data, strb);
      exp_stb = 4'b0001 << addr[3:2];
      model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      checkOutput("bvalid_t1", {127'd0, bvalid}, 128'd1);
      checkOutput("bresp_okay", {126'd0, bresp}, 128'd0);
      checkOutput("wr_stb_t1", {124'd0, reg_wr_stb}, {124'd0, exp_stb});
      checkOutput("fft_start_t1", {127'd0, fft_start}, {127'd0, exp_start});
      checkOutput("reg_out_t1", reg_out, {model[3], model[2], model[1], model[0]});
      @(negedge clk);
      checkOutput("wr_stb_t2", {124'd0, reg_wr_stb}, 128'd0);
      checkOutput("fft_start_t2", {127'd0, fft_start}, 128'd0);
      checkOutput("bvalid_done", {127'd0, bvalid}, 128'd0);
   endtask

   // One full read: scoreboard push at issue, pop/compare when RVALID appears.
   task automatic readBack(input logic [3:0] addr);
      int cyc;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      expq.push_back(model[addr[3:2]]);
      #1;
      cyc = 0;
      while (!arready && cyc < 20) begin
         @(negedge clk); #1; cyc++;
      end
      checkOutput("ar_handshake", {127'd0, (cyc < 20)}, 128'd1);
      @(negedge clk);
      arvalid = 1'b0;
      checkOutput("rvalid_t1", {127'd0, rvalid}, 128'd1);
      if (rvalid) begin
         checkOutput("rdata", {96'd0, rdata}, {96'd0, expq.pop_front()});
         checkOutput("rresp_okay", {126'd0, rresp}, 128'd0);
      end else begin
         void'(expq.pop_front());
      end
      @(negedge clk);
      checkOutput("rvalid_done", {127'd0, rvalid}, 128'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ready"}, {124'd0, awready, wready, arready, 1'b0}, 128'd0);
      checkOutput({tag, "_valid"}, {126'd0, bvalid, rvalid}, 128'd0);
      checkOutput({tag, "_rdata"}, {96'd0, rdata}, 128'd0);
      checkOutput({tag, "_reg_out"}, reg_out, 128'd0);
      checkOutput({tag, "_stb_start"}, {123'd0, reg_wr_stb, fft_start}, 128'd0);
   endtask

   // Directed sequence covering reset, writes, stalls, overlap, strobes, and reset mid-flight.
   initial begin
      int cyc;
      for (int i = 0; i < 4; i++) model[i] = '0;

      #2;
      checkAllZero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] sequential writes and readback");
      applyStimulus(4'h0, 32'h1, 4'hF);
      applyStimulus(4'h4, 32'h2, 4'hF);
      applyStimulus(4'h8, 32'h3, 4'hF);
      applyStimulus(4'hC, 32'h4, 4'hF);
      readBack(4'h0);
      readBack(4'h4);
      readBack(4'h8);
      readBack(4'hC);
      checkOutput("reg_out_seq", reg_out, 128'h00000004_00000003_00000002_00000001);

      $display("[TB] start pulse");
      applyStimulus(4'h0, 32'h1, 4'hF);
      applyStimulus(4'h0, 32'h2, 4'hF);

      $display("[TB] AW before W, held response");
      @(negedge clk);
      awaddr = 4'h4; wdata = 32'h55; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("aw_wait_no_ready", {126'd0, awready, wready}, 128'd0);
         @(negedge clk);
      end
      wvalid = 1'b1;
      #1;
      checkOutput("aw_w_joint", {126'd0, awready, wready}, 128'd3);
      model[1] = merge(model[1], 32'h55, 4'hF);
      @(negedge clk);
      awaddr = 4'h8; wdata = 32'h77;
      checkOutput("held_stb", {124'd0, reg_wr_stb}, 128'd2);
      for (int i = 0; i < 10; i++) begin
         #1;
         checkOutput("held_bvalid", {127'd0, bvalid}, 128'd1);
         checkOutput("held_no_aw", {126'd0, awready, wready}, 128'd0);
         @(negedge clk);
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      @(negedge clk);
      checkOutput("held_released", {127'd0, bvalid}, 128'd0);
      checkOutput("held_reg_out", reg_out, {model[3], model[2], model[1], model[0]});

      $display("[TB] read with concurrent write to the same register");
      @(negedge clk);
      araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
      awaddr = 4'h8; wdata = 32'hDEAD; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      #1;
      checkOutput("overlap_handshakes", {126'd0, arready, awready}, 128'd3);
      old_val = model[2];
      expq.push_back(old_val);
      model[2] = merge(model[2], 32'hDEAD, 4'hF);
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #1;
         checkOutput("overlap_rvalid", {127'd0, rvalid}, 128'd1);
         checkOutput("overlap_rdata_stable", {96'd0, rdata}, {96'd0, expq[0]});
         @(negedge clk);
      end
      rready = 1'b1;
      #1;
      checkOutput("overlap_rdata_old", {96'd0, rdata}, {96'd0, expq.pop_front()});
      @(negedge clk);
      checkOutput("overlap_done", {127'd0, rvalid}, 128'd0);
      readBack(4'h8);

      $display("[TB] byte strobes");
      applyStimulus(4'h4, 32'h11223344, 4'hF);
      applyStimulus(4'h4, 32'hAABBCCDD, 4'b0101);
      readBack(4'h4);
`ifdef FFT_AXIL_WSTRB_EN
      exp_strb_val = 32'h11BB33DD;
`else
      exp_strb_val = 32'hAABBCCDD;
`endif
      checkOutput("strb_reg1", {96'd0, reg_out[63:32]}, {96'd0, exp_strb_val});

      $display("[TB] reset with both responses pending");
      @(negedge clk);
      araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
      awaddr = 4'hC; wdata = 32'h1234; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      cyc = 0;
      checkOutput("pending_both", {126'd0, bvalid, rvalid}, 128'd3);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      for (int i = 0; i < 4; i++) model[i] = '0;
      @(negedge clk);
      rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_no_resp", {126'd0, bvalid, rvalid}, 128'd0);
      readBack(4'h0);
      readBack(4'h4);
      readBack(4'h8);
      readBack(4'hC);
      checkOutput("scoreboard_empty", {96'd0, expq.size()}, 128'd0);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_axil_regs.md
# fft_axil_regs

AXI4-Lite slave register bank for the FFT IP: four 32-bit read/write control registers that the processing system (or the AXI VIP master in the block-design bench) programs over S00_AXI. It sits directly downstream of the AXI interconnect / master and upstream of the FFT datapath, which consumes the register contents and the write-event strobes. Fully independent read and write channels, single outstanding transaction per channel.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.
- ACLK  in  1  sole clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes; see Configuration.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- reg_out  out  128  {reg3, reg2, reg1, reg0}, registered, to the FFT datapath.
- reg_wr_stb  out  4  one-hot, one-cycle pulse on the cycle after register n is written.
- fft_start  out  1  one-cycle pulse on the cycle after a write to reg0 with WDATA[0]=1 (and byte lane 0 enabled).

## Operation
- Write FSM, states W_IDLE, W_RESP. In W_IDLE, when AWVALID and WVALID are both high, AWREADY and WREADY pulse high together for exactly one cycle. The register is updated on that edge, and the FSM moves to W_RESP with BVALID=1.
- W_RESP holds BVALID until BREADY=1, then returns to W_IDLE. AWREADY and WREADY stay 0 while in W_RESP.
- AWVALID without WVALID, or WVALID without AWVALID: no handshake; the block waits. No partial address or data capture.
- Read FSM, states R_IDLE, R_DATA. In R_IDLE with ARVALID=1, ARREADY pulses for one cycle, RDATA is captured from the selected register, and the FSM moves to R_DATA with RVALID=1. RDATA holds stable until RREADY=1, then the FSM returns to R_IDLE.
- The read and write channels are fully concurrent.
- Simultaneous write and read to the same register on the same handshake edge: the read returns the pre-write value.
- All four registers are plain R/W; a read returns the last value written.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert is the system's responsibility) clears all outputs to 0 immediately: READY/VALID signals, RDATA, reg0..reg3, reg_out, reg_wr_stb, fft_start. Both FSMs return to IDLE. Reset during an open transaction drops it; no response is issued.
- Write latency:
  - AW/W handshake edge T.
  - BVALID=1 from T+1.
  - reg_out updated from T+1.
  - reg_wr_stb and fft_start high during cycle T+1 only.
- Read latency: ARREADY handshake at edge T, RVALID=1 with data from T+1.
- Minimum throughput with READY tied high on the master: one write every 2 cycles, one read every 2 cycles.

## Configuration
- FFT_AXIL_WSTRB_EN defined: byte lane k of the target register is updated only when WSTRB[k]=1. A write with WSTRB=4'b0000 still completes with OKAY and a reg_wr_stb pulse, but leaves data unchanged.
- FFT_AXIL_WSTRB_EN undefined: WSTRB is ignored and every write updates the full 32 bits. fft_start depends only on WDATA[0].

## Test plan
- Sequential writes: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read them back -> reads return 0x1..0x4, every BRESP/RRESP = OKAY, and reg_out = 0x00000004_00000003_00000002_00000001.
- Write 0x1 to 0x0 -> fft_start and reg_wr_stb=4'b0001 each high for exactly one cycle, the cycle after the handshake. Write 0x2 to 0x0 -> reg_wr_stb pulses, fft_start stays 0.
- Present AWVALID 5 cycles before WVALID -> no AWREADY until WVALID rises; a single joint handshake follows. Hold BREADY low 10 cycles -> BVALID held and no second AW accepted.
- Issue a read of 0x8 with RREADY low 7 cycles, with a write of 0xDEAD to 0x8 on the same edge as the AR handshake -> RDATA stays at the old value, stable until RREADY; a following read returns 0xDEAD.
- With FFT_AXIL_WSTRB_EN: write 0xAABBCCDD with WSTRB=4'b0101 over 0x11223344 -> readback 0x11BB33DD. Without the macro -> readback 0xAABBCCDD.
- Assert ARESETN=0 while BVALID and RVALID are both pending -> all outputs are 0 in the same cycle, and after release all registers read back 0.
